// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse key input stage: FSM states,
// symbol encoding, digit patterns and the pattern-to-digit decoder.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    GAP,
    DECODE
  } state_t;

  localparam logic SYM_DOT  = 1'b0;
  localparam logic SYM_DASH = 1'b1;

  // Five-symbol digit patterns, first symbol in the MSB, dash = 1.
  localparam logic [4:0] PAT_0 = 5'b11111;
  localparam logic [4:0] PAT_1 = 5'b01111;
  localparam logic [4:0] PAT_2 = 5'b00111;
  localparam logic [4:0] PAT_3 = 5'b00011;
  localparam logic [4:0] PAT_4 = 5'b00001;
  localparam logic [4:0] PAT_5 = 5'b00000;
  localparam logic [4:0] PAT_6 = 5'b10000;
  localparam logic [4:0] PAT_7 = 5'b11000;
  localparam logic [4:0] PAT_8 = 5'b11100;
  localparam logic [4:0] PAT_9 = 5'b11110;

  typedef struct packed {
    logic       valid;
    logic [3:0] digit;
  } decode_t;

  // Map a complete five-symbol pattern to its BCD digit.
  function automatic decode_t pattern_to_digit(input logic [4:0] pat);
    decode_t res;
    res.valid = 1'b1;
    res.digit = 4'd0;
    case (pat)
      PAT_0:   res.digit = 4'd0;
      PAT_1:   res.digit = 4'd1;
      PAT_2:   res.digit = 4'd2;
      PAT_3:   res.digit = 4'd3;
      PAT_4:   res.digit = 4'd4;
      PAT_5:   res.digit = 4'd5;
      PAT_6:   res.digit = 4'd6;
      PAT_7:   res.digit = 4'd7;
      PAT_8:   res.digit = 4'd8;
      PAT_9:   res.digit = 4'd9;
      default: res.valid = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/morse_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer. The output
// level follows the synchronised key only after it has held a new value
// for DEBOUNCE_CYC consecutive cycles.
module morse_debounce #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic kd
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DW-1:0] STABLE_LAST = DW'(DEBOUNCE_CYC - 1);

  logic          sync_1;
  logic          sync_2;
  logic [DW-1:0] stable_cnt;

  // Synchronise the asynchronous key into the clk domain.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, as real flops do.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= key;
      sync_2 <= sync_1;
    end
  end

  // Accept a level change once the new value has been stable long enough.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_cnt <= '0;
      kd         <= 1'b0;
    end else if (sync_2 == kd) begin
      stable_cnt <= '0;
    end else if (stable_cnt == STABLE_LAST) begin
      stable_cnt <= '0;
      kd         <= sync_2;
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/morse_keyer.sv
// Morse key to BCD operand front end. Classifies debounced presses as
// dot/dash, collects five-symbol characters and loads decoded digits
// alternately into operand a and operand b.
module morse_keyer
  import morse_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 16,
  parameter int DASH_CYC     = 64,
  parameter int GAP_CYC      = 128,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       digit_valid,
  output logic       pair_valid,
  output logic       err,
  output logic       sel_b
);

  // The first high cycle of a press is spent leaving IDLE/GAP, so a press
  // of N debounced cycles leaves N-1 in the counter at release.
  localparam logic [CNT_W-1:0] DASH_LAST = CNT_W'(DASH_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC);

  logic             kd;
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       shift_reg;
  logic [2:0]       nsym;
  logic             overflow;

  logic             cnt_clr;
  logic             cnt_inc;
  logic             sym_push;
  logic             do_decode;
  logic             sym;
  decode_t          dec;

  morse_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_debounce (
    .clk   (clk),
    .reset (reset),
    .key   (key),
    .kd    (kd)
  );

  assign sym = (cnt >= DASH_LAST) ? SYM_DASH : SYM_DOT;
  assign dec = pattern_to_digit(shift_reg);

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and datapath strobes; gap expiry wins over a new press.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    sym_push   = 1'b0;
    do_decode  = 1'b0;
    case (state)
      IDLE: begin
        if (kd) begin
          state_next = PRESS;
          cnt_clr    = 1'b1;
        end
      end
      PRESS: begin
        if (!kd) begin
          sym_push   = 1'b1;
          state_next = GAP;
          cnt_clr    = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      GAP: begin
        if (cnt >= GAP_LAST) begin
          state_next = DECODE;
          do_decode  = 1'b1;
        end else if (kd) begin
          state_next = PRESS;
          cnt_clr    = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DECODE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Saturating press/gap counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (cnt_inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Symbol collection; a sixth symbol only marks the character as bad.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg <= '0;
      nsym      <= '0;
      overflow  <= 1'b0;
    end else if (do_decode) begin
      shift_reg <= '0;
      nsym      <= '0;
      overflow  <= 1'b0;
    end else if (sym_push) begin
      if (nsym == 3'd5) begin
        overflow <= 1'b1;
      end else begin
        shift_reg <= {shift_reg[3:0], sym};
        nsym      <= nsym + 3'd1;
      end
    end
  end

  // Operand registers and registered one-cycle result pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a           <= 4'd0;
      b           <= 4'd0;
      sel_b       <= 1'b0;
      digit_valid <= 1'b0;
      pair_valid  <= 1'b0;
      err         <= 1'b0;
    end else begin
      digit_valid <= 1'b0;
      pair_valid  <= 1'b0;
      err         <= 1'b0;
      if (do_decode) begin
        if (dec.valid && (nsym == 3'd5) && !overflow) begin
          digit_valid <= 1'b1;
          sel_b       <= ~sel_b;
          if (sel_b) begin
            b          <= dec.digit;
            pair_valid <= 1'b1;
          end else begin
            a <= dec.digit;
          end
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_morse_keyer.sv
// Directed bench for morse_keyer: reset state, digit decode and operand
// steering, rejected characters, dot/dash boundary, glitch rejection and
// asynchronous reset mid-character.
module tb_morse_keyer;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       key   = 1'b0;
  logic [3:0] a;
  logic [3:0] b;
  logic       digit_valid;
  logic       pair_valid;
  logic       err;
  logic       sel_b;

  int checks   = 0;
  int failures = 0;

  int dv_cnt   = 0;
  int pv_cnt   = 0;
  int err_cnt  = 0;
  int both_cnt = 0;

  always #5 clk = ~clk;

  morse_keyer #(
    .DEBOUNCE_CYC (4),
    .DASH_CYC     (20),
    .GAP_CYC      (40),
    .CNT_W        (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key         (key),
    .a           (a),
    .b           (b),
    .digit_valid (digit_valid),
    .pair_valid  (pair_valid),
    .err         (err),
    .sel_b       (sel_b)
  );

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (digit_valid)               dv_cnt   <= dv_cnt + 1;
    if (pair_valid)                pv_cnt   <= pv_cnt + 1;
    if (err)                       err_cnt  <= err_cnt + 1;
    if (digit_valid && pair_valid) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int n);
    key = 1'b1;
    tick(n);
    key = 1'b0;
  endtask

  // Dots 10 cycles, dashes 30, 10-cycle gaps between symbols.
  task automatic send_syms(input string s);
    for (int i = 0; i < s.len(); i++) begin
      press((s[i] == "-") ? 30 : 10);
      if (i != s.len() - 1) tick(10);
    end
  endtask

  task automatic send_char(input string s);
    send_syms(s);
    tick(60);
  endtask

  initial begin
    int dv0, pv0, err0, both0;

    // Reset state
    tick(3);
    check("rst_a", int'(a), 0);
    check("rst_b", int'(b), 0);
    check("rst_dv", int'(digit_valid), 0);
    check("rst_pv", int'(pair_valid), 0);
    check("rst_err", int'(err), 0);
    check("rst_sel_b", int'(sel_b), 0);
    reset = 1'b1;
    tick(5);

    // "..---" -> a=2, pulse 48 edges after the final release
    dv0 = dv_cnt; err0 = err_cnt;
    send_syms("..---");
    tick(47);
    check("t1_dv_early", int'(digit_valid), 0);
    tick(1);
    check("t1_dv_pulse", int'(digit_valid), 1);
    check("t1_a", int'(a), 2);
    check("t1_sel_b", int'(sel_b), 1);
    check("t1_err", int'(err), 0);
    tick(12);
    check("t1_dv_count", dv_cnt - dv0, 1);
    check("t1_err_count", err_cnt - err0, 0);

    // "----." -> b=9, returns the selector to a
    send_char("----.");
    check("fill_b", int'(b), 9);
    check("fill_sel_b", int'(sel_b), 0);

    // 7 then 3 -> a=7, b=3, digit_valid and pair_valid together
    dv0 = dv_cnt; pv0 = pv_cnt; both0 = both_cnt;
    send_char("--...");
    check("t2_a", int'(a), 7);
    check("t2_sel_b_mid", int'(sel_b), 1);
    send_char("...--");
    check("t2_b", int'(b), 3);
    check("t2_a_kept", int'(a), 7);
    check("t2_sel_b", int'(sel_b), 0);
    check("t2_dv_count", dv_cnt - dv0, 2);
    check("t2_pv_count", pv_cnt - pv0, 1);
    check("t2_both_count", both_cnt - both0, 1);

    // Three dots -> err, operands untouched
    dv0 = dv_cnt; err0 = err_cnt;
    send_char("...");
    check("t3_err_count", err_cnt - err0, 1);
    check("t3_dv_count", dv_cnt - dv0, 0);
    check("t3_a", int'(a), 7);
    check("t3_b", int'(b), 3);
    check("t3_sel_b", int'(sel_b), 0);

    // Six dots -> err, then "-----" -> a=0
    dv0 = dv_cnt; err0 = err_cnt;
    send_char("......");
    check("t4_err_count", err_cnt - err0, 1);
    check("t4_a_kept", int'(a), 7);
    send_char("-----");
    check("t4_a", int'(a), 0);
    check("t4_dv_count", dv_cnt - dv0, 1);
    check("t4_err_total", err_cnt - err0, 1);
    check("t4_sel_b", int'(sel_b), 1);

    // 19-cycle dot, 20-cycle dashes, 3-cycle glitches -> "1" into b
    dv0 = dv_cnt; pv0 = pv_cnt; err0 = err_cnt;
    press(19); tick(10);
    press(3);  tick(10);
    press(20); tick(10);
    press(20); tick(5);
    press(3);  tick(5);
    press(20); tick(10);
    press(20); tick(60);
    check("t5_b", int'(b), 1);
    check("t5_a_kept", int'(a), 0);
    check("t5_pv_count", pv_cnt - pv0, 1);
    check("t5_err_count", err_cnt - err0, 0);
    check("t5_sel_b", int'(sel_b), 0);

    // "....-" -> a=4 so the reset below has nonzero state to clear
    send_char("....-");
    check("t6_a", int'(a), 4);
    check("t6_sel_b", int'(sel_b), 1);

    // Reset after three symbols clears outputs asynchronously
    send_syms("...");
    tick(5);
    reset = 1'b0;
    #1;
    check("t7_rst_a", int'(a), 0);
    check("t7_rst_b", int'(b), 0);
    check("t7_rst_sel_b", int'(sel_b), 0);
    check("t7_rst_dv", int'(digit_valid), 0);
    check("t7_rst_err", int'(err), 0);
    tick(3);
    reset = 1'b1;
    tick(5);

    // Partial symbols were discarded: "....." decodes to a=5
    dv0 = dv_cnt; err0 = err_cnt;
    send_char(".....");
    check("t7_a", int'(a), 5);
    check("t7_b", int'(b), 0);
    check("t7_sel_b", int'(sel_b), 1);
    check("t7_dv_count", dv_cnt - dv0, 1);
    check("t7_err_count", err_cnt - err0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
